weight_loader: RTL and testbench



---
 rtl/weight_loader_pkg.sv | 17 +
 rtl/loader_addr_gen.sv | 83 ++++++++
 rtl/weight_loader.sv | 118 +++++++++++
 tb/tb_weight_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/weight_loader_pkg.sv
// Shared definitions for the weight loader: FSM state encoding and the
// width helper for the one-hot per-neuron enable vectors.
package weight_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    // One enable bit per neuron memory; never narrower than one bit.
    function automatic int onehot_width(input int num_neuron);
        return (num_neuron < 1) ? 1 : num_neuron;
    endfunction

endpackage

// File: rtl/loader_addr_gen.sv
// Neuron-major address generator: weight and neuron counters, wrap detection
// and final-word detection. With WEIGHT_LOADER_BIAS_EN a bias slot follows each neuron.
module loader_addr_gen
    import weight_loader_pkg::*;
#(
    parameter int numNeuron    = 30,
    parameter int numWeight    = 784,
    parameter int addressWidth = 10,
    parameter int neuronWidth  = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    advance,
    output logic [addressWidth-1:0] weight_idx,
    output logic [neuronWidth-1:0]  neuron_idx,
    output logic                    is_bias,
    output logic                    is_final
);

    localparam logic [addressWidth-1:0] LastWeight = addressWidth'(numWeight - 1);
    localparam logic [neuronWidth-1:0]  LastNeuron = neuronWidth'(numNeuron - 1);

    logic weight_wrap;
    logic last_neuron;

    assign weight_wrap = (weight_idx == LastWeight);
    assign last_neuron = (neuron_idx == LastNeuron);

`ifdef WEIGHT_LOADER_BIAS_EN
    // The bias slot is a separate flag so numWeight may equal 2^addressWidth.
    logic bias_phase;

    assign is_bias  = bias_phase;
    assign is_final = last_neuron && bias_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_idx <= '0;
            neuron_idx <= '0;
            bias_phase <= 1'b0;
        end else if (clear) begin
            weight_idx <= '0;
            neuron_idx <= '0;
            bias_phase <= 1'b0;
        end else if (advance) begin
            if (bias_phase) begin
                bias_phase <= 1'b0;
                weight_idx <= '0;
                neuron_idx <= neuron_idx + 1'b1;
            end else if (weight_wrap) begin
                bias_phase <= 1'b1;
                weight_idx <= '0;
            end else begin
                weight_idx <= weight_idx + 1'b1;
            end
        end
    end
`else
    assign is_bias  = 1'b0;
    assign is_final = last_neuron && weight_wrap;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_idx <= '0;
            neuron_idx <= '0;
        end else if (clear) begin
            weight_idx <= '0;
            neuron_idx <= '0;
        end else if (advance) begin
            if (weight_wrap) begin
                weight_idx <= '0;
                neuron_idx <= neuron_idx + 1'b1;
            end else begin
                weight_idx <= weight_idx + 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/weight_loader.sv
// Streams neuron-major weight words into per-neuron memory write ports.
// Optional bias words per neuron when WEIGHT_LOADER_BIAS_EN is defined.
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int numNeuron    = 30,
    parameter int numWeight    = 784,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16,
    parameter int neuronWidth  = 5
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [dataWidth-1:0]                 in_data,
    input  logic                                 in_last,
    output logic [onehot_width(numNeuron)-1:0]   w_en,
    output logic [addressWidth-1:0]              w_add,
    output logic [dataWidth-1:0]                 w_in,
`ifdef WEIGHT_LOADER_BIAS_EN
    output logic [onehot_width(numNeuron)-1:0]   b_en,
    output logic [dataWidth-1:0]                 b_in,
`endif
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);

    localparam int EnW = onehot_width(numNeuron);

    state_t state, state_next;

    logic                    accept;
    logic                    clear;
    logic [addressWidth-1:0] weight_idx;
    logic [neuronWidth-1:0]  neuron_idx;
    logic                    is_bias;
    logic                    is_final;
    logic [EnW-1:0]          neuron_hot;

    assign accept     = in_valid && (state == LOAD);
    assign clear      = start && ((state == IDLE) || (state == ERR));
    assign neuron_hot = EnW'(1) << neuron_idx;

    // Status outputs decode directly from the state register.
    assign in_ready = (state == LOAD);
    assign busy     = (state == LOAD);
    assign done     = (state == DONE);
    assign err      = (state == ERR);

    loader_addr_gen #(
        .numNeuron    (numNeuron),
        .numWeight    (numWeight),
        .addressWidth (addressWidth),
        .neuronWidth  (neuronWidth)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .advance    (accept),
        .weight_idx (weight_idx),
        .neuron_idx (neuron_idx),
        .is_bias    (is_bias),
        .is_final   (is_final)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: state_next gets its default before any branch, so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: begin
                if (accept) begin
                    if (is_final)     state_next = in_last ? DONE : ERR;
                    else if (in_last) state_next = ERR;
                end
            end
            DONE: state_next = IDLE;
            ERR:  if (start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    // Write port: enables pulse for one cycle; address and data hold between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_en  <= '0;
            w_add <= '0;
            w_in  <= '0;
        end else begin
            w_en <= (accept && !is_bias) ? neuron_hot : '0;
            if (accept && !is_bias) begin
                w_add <= weight_idx;
                w_in  <= in_data;
            end
        end
    end

`ifdef WEIGHT_LOADER_BIAS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_en <= '0;
            b_in <= '0;
        end else begin
            b_en <= (accept && is_bias) ? neuron_hot : '0;
            if (accept && is_bias) b_in <= in_data;
        end
    end
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader with 2 neurons x 3 weights; the bias scenario
// runs only when WEIGHT_LOADER_BIAS_EN is defined.
module tb_weight_loader;

    localparam int NN  = 2;
    localparam int NW  = 3;
    localparam int AW  = 2;
    localparam int DW  = 16;
    localparam int NWD = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic [NN-1:0] w_en;
    logic [AW-1:0] w_add;
    logic [DW-1:0] w_in;
    logic          busy, done, err;
`ifdef WEIGHT_LOADER_BIAS_EN
    logic [NN-1:0] b_en;
    logic [DW-1:0] b_in;
`endif

    weight_loader #(
        .numNeuron(NN), .numWeight(NW), .addressWidth(AW),
        .dataWidth(DW), .neuronWidth(NWD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .w_en(w_en), .w_add(w_add), .w_in(w_in),
`ifdef WEIGHT_LOADER_BIAS_EN
        .b_en(b_en), .b_in(b_in),
`endif
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NN-1:0] en;
        logic [AW-1:0] add;
        logic [DW-1:0] data;
    } wr_t;

    wr_t wq[$];
    wr_t bq[$];
    int  done_cnt = 0;
    int  done_on_write = 0;
    int  checks = 0;
    int  errors = 0;

    // Write monitor, sampled on the falling edge away from register updates.
    always @(negedge clk) begin
        if (w_en != '0) wq.push_back({w_en, w_add, w_in});
`ifdef WEIGHT_LOADER_BIAS_EN
        if (b_en != '0) bq.push_back({b_en, {AW{1'b0}}, b_in});
        if (done && (w_en != '0 || b_en != '0)) done_on_write++;
`else
        if (done && w_en != '0) done_on_write++;
`endif
        if (done) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] data, input logic last, input bit gap);
        bit acc = 1'b0;
        int n = 0;
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        while (!acc && n < 50) begin
            acc = in_ready;
            tick();
            n++;
        end
        if (!acc) check("handshake_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (gap) tick();
    endtask

    task automatic clear_mon();
        wq.delete();
        bq.delete();
        done_cnt = 0;
        done_on_write = 0;
    endtask

    task automatic check_writes(input string name, input wr_t exp[6]);
        check({name, "_count"}, wq.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < wq.size()) check($sformatf("%s_wr%0d", name, i), 32'(wq[i]), 32'(exp[i]));
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_w_en"}, 32'(w_en), 0);
        check({name, "_w_add"}, 32'(w_add), 0);
        check({name, "_w_in"}, 32'(w_in), 0);
        check({name, "_flags"}, {28'd0, in_ready, busy, done, err}, 0);
    endtask

    wr_t exp_nom[6];

    initial begin
        // Expected write table: neuron 0 takes words 1..3, neuron 1 takes 4..6.
        for (int i = 0; i < 6; i++)
            exp_nom[i] = {NN'(i < 3 ? 1 : 2), AW'(i % 3), DW'(i + 1)};

        repeat (2) tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick();
        check_outputs_zero("idle");

`ifdef WEIGHT_LOADER_BIAS_EN
        // Bias build: words 4 and 8 are biases, word 8 ends the layer.
        clear_mon();
        pulse_start();
        for (int i = 1; i <= 8; i++) send(DW'(i), i == 8, 1'b0);
        tick();
        check("bias_w_count", wq.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < wq.size())
                check($sformatf("bias_w%0d", i), 32'(wq[i]),
                      32'({NN'(i < 3 ? 1 : 2), AW'(i % 3), DW'(i < 3 ? i + 1 : i + 2)}));
        check("bias_b_count", bq.size(), 2);
        if (bq.size() > 0) check("bias_b0", 32'(bq[0]), 32'({2'b01, 2'b00, 16'd4}));
        if (bq.size() > 1) check("bias_b1", 32'(bq[1]), 32'({2'b10, 2'b00, 16'd8}));
        check("bias_done", done_cnt, 1);
        check("bias_done_on_write", done_on_write, 1);
        check("bias_err", err, 0);
`else
        // Nominal back-to-back load.
        clear_mon();
        pulse_start();
        check("load_flags", {in_ready, busy, done, err}, 4'b1100);
        for (int i = 1; i <= 6; i++) send(DW'(i), i == 6, 1'b0);
        tick();
        check_writes("nominal", exp_nom);
        check("nominal_done", done_cnt, 1);
        check("nominal_done_on_write", done_on_write, 1);
        check("nominal_err", err, 0);
        check("nominal_busy_after", busy, 0);
        repeat (2) tick();

        // Backpressure with idle gaps and a stray start mid-load.
        clear_mon();
        pulse_start();
        for (int i = 1; i <= 6; i++) begin
            send(DW'(i), i == 6, 1'b1);
            if (i == 2) pulse_start();
        end
        tick();
        check_writes("backpressure", exp_nom);
        check("backpressure_done", done_cnt, 1);
        repeat (2) tick();

        // Early in_last on word 4.
        clear_mon();
        pulse_start();
        for (int i = 1; i <= 4; i++) send(DW'(i), i == 4, 1'b0);
        check("early_err", err, 1);
        check("early_ready", in_ready, 0);
        in_valid = 1'b1;
        in_data  = 16'h00AA;
        repeat (3) tick();
        in_valid = 1'b0;
        tick();
        check("early_count", wq.size(), 4);
        if (wq.size() > 3) check("early_wr3", 32'(wq[3]), 32'({2'b10, 2'b00, 16'd4}));
        check("early_done", done_cnt, 0);
        check("early_err_sticky", err, 1);
        pulse_start();
        check("early_restart_err", err, 0);
        check("early_restart_busy", busy, 1);

        // Missing in_last on word 6 (continues the load started above).
        clear_mon();
        for (int i = 1; i <= 6; i++) send(DW'(i), 1'b0, 1'b0);
        tick();
        check_writes("nolast", exp_nom);
        check("nolast_err", err, 1);
        check("nolast_done", done_cnt, 0);
        repeat (2) tick();

        // Reset right after word 3, then a clean reload.
        pulse_start();
        for (int i = 1; i <= 3; i++) send(DW'(i), 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        tick();
        rst_n = 1'b1;
        tick();
        clear_mon();
        pulse_start();
        for (int i = 1; i <= 6; i++) send(DW'(i), i == 6, 1'b0);
        tick();
        check_writes("reload", exp_nom);
        check("reload_done", done_cnt, 1);
        check("reload_err", err, 0);
`endif

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
